// File: rtl/bsg_fsb_hop_in_pkg.sv
// Shared types for the front-side bus receive hop.
// Port indices and the routing target encoding.
package bsg_fsb_hop_in_pkg;

  localparam int unsigned port_local = 0;
  localparam int unsigned port_fwd   = 1;

  typedef enum logic [1:0] {
    tgt_none  = 2'b00,
    tgt_local = 2'b01,
    tgt_fwd   = 2'b10,
    tgt_both  = 2'b11
  } target_e;

endpackage

// File: rtl/bsg_fsb_hop_in_if.sv
// Bus bundle of the receive hop: one ready/valid input stream
// plus the packed two-channel output (v_o, data_o, yumi_i).
interface bsg_fsb_hop_in_if #(
  parameter int width_p    = 16,
  parameter int id_width_p = 4
);
  logic [id_width_p-1:0] my_id_i;
  logic                  v_i;
  logic [width_p-1:0]    data_i;
  logic                  ready_o;
  logic [1:0]            v_o;
  logic [2*width_p-1:0]  data_o;
  logic [1:0]            yumi_i;

  modport master (
    output my_id_i, v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  my_id_i, v_i, data_i, yumi_i,
    output ready_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_front_side_bus_hop_in_fifo.sv
// Two-entry FIFO, async active-high reset.
// Enq: ready_o/v_i/data_i. Deq: v_o/data_o/deq_i.
module bsg_front_side_bus_hop_in_fifo #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               deq_i
);

  logic [width_p-1:0] mem_r [2];
  logic               head_r;
  logic               tail_r;
  logic [1:0]         cnt_r;
  logic               enq;
  logic               deq;

  assign ready_o = (cnt_r != 2'd2);
  assign v_o     = (cnt_r != 2'd0);
  assign data_o  = mem_r[head_r];
  assign enq     = v_i & ready_o;
  assign deq     = deq_i & v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_r <= 1'b0;
      tail_r <= 1'b0;
      cnt_r  <= 2'd0;
    end else begin
      if (enq) tail_r <= ~tail_r;
      if (deq) head_r <= ~head_r;
      unique case ({enq, deq})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[tail_r] <= data_i;
  end

endmodule

// File: rtl/bsg_front_side_bus_hop_in.sv
// Receive hop: buffers the ring stream, routes head word to
// local (v_o[0]) / forward (v_o[1]) / both. Macro: BSG_FSB_HOP_IN_BCAST_EN.
module bsg_front_side_bus_hop_in
  import bsg_fsb_hop_in_pkg::*;
#(
  parameter int width_p    = 16,
  parameter int id_width_p = 4
) (
  input logic              clk_i,
  input logic              reset_i,
  bsg_fsb_hop_in_if.slave  bus
);

  logic                  head_v;
  logic [width_p-1:0]    head;
  logic                  deq;
  logic [id_width_p-1:0] dest;
  target_e               target;

  bsg_front_side_bus_hop_in_fifo #(
    .width_p (width_p)
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (bus.ready_o),
    .v_i     (bus.v_i),
    .data_i  (bus.data_i),
    .v_o     (head_v),
    .data_o  (head),
    .deq_i   (deq)
  );

  assign dest        = head[width_p-1 -: id_width_p];
  assign bus.data_o  = {head, head};

`ifdef BSG_FSB_HOP_IN_BCAST_EN
  logic [1:0] sent_r;

  always_comb begin
    target = tgt_fwd;
    unique case (1'b1)
      (dest == bus.my_id_i):     target = tgt_local;
      (dest == {id_width_p{1'b1}}): target = tgt_both;
      default:                   target = tgt_fwd;
    endcase
  end

  assign bus.v_o = {2{head_v}} & target & ~sent_r;
  assign deq = head_v &
    ((target & ~(sent_r | bus.yumi_i)) == 2'b00);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)  sent_r <= 2'b00;
    else if (deq) sent_r <= 2'b00;
    else          sent_r <= sent_r | (bus.yumi_i & target);
  end
`else
  // All-ones dest is just another foreign id here.
  assign target  = (dest == bus.my_id_i) ? tgt_local : tgt_fwd;
  assign bus.v_o = {2{head_v}} & target;
  assign deq     = head_v & |(bus.yumi_i & target);
`endif

  a_yumi_needs_v: assert property (
    @(posedge clk_i) disable iff (reset_i)
    (bus.yumi_i & ~bus.v_o) == 2'b00
  );

endmodule
